// File: rtl/mlp_cls_head.sv
// rtl/mlp_cls_head.sv - mean-pool + serial-MAC fully connected classification head with argmax
//
// Mean-pools each feature column of a token-by-feature matrix. The pooled
// vector then goes through a features-to-classes linear layer, evaluated one
// MAC per cycle. Each class logit is saturated, and the class with the
// greatest logit is picked (ties go to the lower index).
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin one classification (sampled only while idle)
//   mat_in   - signed [token][feature] matrix, held stable until done
//   head_wt  - signed weights, weight(c,k) = head_wt[c*MATRIX_SIZE+k]
//   head_bs  - signed per-class bias in integer units
//   busy     - high while pooling, accumulating or signalling done
//   done     - one-cycle pulse when logits/class_id are valid
//   logits   - saturated per-class logits, held until overwritten
//   class_id - argmax class index, held until overwritten
module mlp_cls_head #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASS   = 5,
  parameter int FRAC_SHIFT  = 4,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] mat_in,
  input  logic [NUM_CLASS*MATRIX_SIZE-1:0][DATA_WIDTH-1:0]       head_wt,
  input  logic [NUM_CLASS-1:0][DATA_WIDTH-1:0]                   head_bs,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [NUM_CLASS-1:0][DATA_WIDTH-1:0]                   logits,
  output logic [$clog2(NUM_CLASS)-1:0]                           class_id
);

  localparam int LOG2 = $clog2(MATRIX_SIZE);
  localparam int CW   = $clog2(NUM_CLASS);
  localparam int SW   = DATA_WIDTH + LOG2;

  // The row counter runs one past the last row: that extra step turns the
  // complete column sums into pooled means.
  localparam logic [LOG2:0]   R_POOLED = (LOG2+1)'(MATRIX_SIZE);
  localparam logic [LOG2-1:0] K_LAST   = LOG2'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0]   C_LAST   = CW'(NUM_CLASS - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, POOL, FC, DONE} state_t;

  state_t                                   state_q, state_d;
  logic [LOG2:0]                            r_q, r_d;
  logic [LOG2-1:0]                          k_q, k_d;
  logic [CW-1:0]                            c_q, c_d;
  logic [MATRIX_SIZE-1:0][SW-1:0]           colsum_q, colsum_d;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]   pooled_q, pooled_d;
  logic signed [ACC_WIDTH-1:0]              acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]             best_q, best_d;
  logic [NUM_CLASS-1:0][DATA_WIDTH-1:0]     logits_q, logits_d;
  logic [CW-1:0]                            class_q, class_d;
  logic                                     done_q, done_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_base;
  logic signed [ACC_WIDTH-1:0]    acc_new;
  logic signed [ACC_WIDTH-1:0]    acc_shr;
  logic signed [DATA_WIDTH-1:0]   v_sat;

  // Datapath for the FC step; only consumed while in FC.
  always_comb begin
    prod     = $signed(pooled_q[k_q]) * $signed(head_wt[{c_q, k_q}]);
    acc_base = (k_q == '0) ? (ACC_WIDTH'($signed(head_bs[c_q])) <<< FRAC_SHIFT) : acc_q;
    acc_new  = acc_base + ACC_WIDTH'(prod);
    acc_shr  = acc_new >>> FRAC_SHIFT;
    if (acc_shr > SAT_MAX) begin
      v_sat = DATA_WIDTH'(SAT_MAX);
    end else if (acc_shr < SAT_MIN) begin
      v_sat = DATA_WIDTH'(SAT_MIN);
    end else begin
      v_sat = DATA_WIDTH'(acc_shr);
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    k_d      = k_q;
    c_d      = c_q;
    colsum_d = colsum_q;
    pooled_d = pooled_q;
    acc_d    = acc_q;
    best_d   = best_q;
    logits_d = logits_q;
    class_d  = class_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = POOL;
          r_d      = '0;
          k_d      = '0;
          c_d      = '0;
          colsum_d = '0;
        end
      end
      POOL: begin
        if (r_q == R_POOLED) begin
          // Arithmetic shift gives floor division; the mean of DATA_WIDTH
          // values always fits back in DATA_WIDTH.
          for (int i = 0; i < MATRIX_SIZE; i++) begin
            pooled_d[i] = DATA_WIDTH'($signed(colsum_q[i]) >>> LOG2);
          end
          state_d = FC;
        end else begin
          for (int i = 0; i < MATRIX_SIZE; i++) begin
            colsum_d[i] = SW'($signed(colsum_q[i]) + SW'($signed(mat_in[r_q[LOG2-1:0]][i])));
          end
          r_d = r_q + 1'b1;
        end
      end
      FC: begin
        acc_d = acc_new;
        if (k_q == K_LAST) begin
          logits_d[c_q] = v_sat;
          if (c_q == '0 || v_sat > best_q) begin
            best_d  = v_sat;
            class_d = c_q;
          end
          k_d = '0;
          c_d = c_q + 1'b1;
          if (c_q == C_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      k_q      <= '0;
      c_q      <= '0;
      colsum_q <= '0;
      pooled_q <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      logits_q <= '0;
      class_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      k_q      <= k_d;
      c_q      <= c_d;
      colsum_q <= colsum_d;
      pooled_q <= pooled_d;
      acc_q    <= acc_d;
      best_q   <= best_d;
      logits_q <= logits_d;
      class_q  <= class_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign logits   = logits_q;
  assign class_id = class_q;

endmodule

// File: tb/tb_mlp_cls_head.sv
// tb/tb_mlp_cls_head.sv - scoreboard bench for mlp_cls_head
module tb_mlp_cls_head;

  localparam int MS  = 16;
  localparam int DW  = 8;
  localparam int NC  = 5;
  localparam int LAT = 97;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [MS-1:0][MS-1:0][DW-1:0] mat = '0;
  logic [NC*MS-1:0][DW-1:0]     wt = '0;
  logic [NC-1:0][DW-1:0]        bs = '0;
  logic                         busy;
  logic                         done;
  logic [NC-1:0][DW-1:0]        logits;
  logic [2:0]                   class_id;

  typedef struct packed {
    logic [NC-1:0][DW-1:0] lg;
    logic [2:0]            cid;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   n_vec = 0;
  int   n_err = 0;

  mlp_cls_head dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mat_in   (mat),
    .head_wt  (wt),
    .head_bs  (bs),
    .busy     (busy),
    .done     (done),
    .logits   (logits),
    .class_id (class_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model written from the arithmetic definition in plain ints.
  function automatic exp_t model();
    exp_t e;
    int   p[MS];
    int   s, acc, v, best;
    e = '0;
    best = 0;
    for (int k = 0; k < MS; k++) begin
      s = 0;
      for (int r = 0; r < MS; r++) s += int'($signed(mat[r][k]));
      p[k] = s >>> 4;
    end
    for (int c = 0; c < NC; c++) begin
      acc = int'($signed(bs[c])) * 16;
      for (int k = 0; k < MS; k++) acc += p[k] * int'($signed(wt[c*MS+k]));
      v = acc >>> 4;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      e.lg[c] = DW'(v);
      if (c == 0 || v > best) begin
        best  = v;
        e.cid = 3'(c);
      end
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_logit%0d", tag, c), int'($signed(logits[c])), int'($signed(e.lg[c])));
    end
    check($sformatf("%s_class", tag), int'(class_id), int'(e.cid));
  endtask

  // One classification: start at edge 0; optional extra start pulse inside
  // the run (poke > 0 gives the cycle). Checks latency, pulse width, result
  // and that the previous result is held early in the run.
  task automatic run(input string tag, input int poke);
    exp_t e;
    int   cyc;
    sb.push_back(model());
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke > 0 && cyc == poke);
      if (cyc == 5) check_outputs({tag, "_hold"}, held);
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_busy_at_done"}, int'(busy), 1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs(tag, e);
      held = e;
    end
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    held = '0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_outputs("rst", held);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero matrix: logits equal bias, class 3.
    mat = '0;
    for (int i = 0; i < NC*MS; i++) wt[i] = DW'($urandom_range(0, 255));
    bs = {8'sd2, 8'sd7, 8'sd0, -8'sd1, 8'sd3};
    run("zero", 0);
    check("zero_const_class", int'(class_id), 3);
    check("zero_const_l1", int'($signed(logits[1])), -1);

    // All 16 with unit weights on class 2.
    for (int r = 0; r < MS; r++) for (int k = 0; k < MS; k++) mat[r][k] = 8'd16;
    wt = '0;
    for (int k = 0; k < MS; k++) wt[2*MS+k] = 8'd1;
    bs = '0;
    run("unit", 0);
    check("unit_const_l2", int'($signed(logits[2])), 16);

    // Positive and negative saturation.
    for (int r = 0; r < MS; r++) for (int k = 0; k < MS; k++) mat[r][k] = 8'd127;
    wt = '0;
    for (int k = 0; k < MS; k++) wt[k] = 8'd127;
    run("satp", 0);
    check("satp_const_l0", int'($signed(logits[0])), 127);
    for (int k = 0; k < MS; k++) wt[k] = 8'h80;
    run("satn", 0);
    check("satn_const_l0", int'($signed(logits[0])), -128);
    check("satn_const_class", int'(class_id), 1);

    // Floor pooling of -1/16 and tie rule.
    mat = '0;
    for (int k = 0; k < MS; k++) mat[0][k] = 8'hFF;
    wt = '0;
    for (int k = 0; k < MS; k++) wt[MS+k] = 8'd16;
    run("floor", 0);
    check("floor_const_l1", int'($signed(logits[1])), -16);
    check("floor_const_class", int'(class_id), 0);

    // Random data with a stray start pulse during FC.
    for (int r = 0; r < MS; r++) for (int k = 0; k < MS; k++) mat[r][k] = DW'($urandom_range(0, 255));
    for (int i = 0; i < NC*MS; i++) wt[i] = DW'($urandom_range(0, 63) - 32);
    for (int c = 0; c < NC; c++) bs[c] = DW'($urandom_range(0, 31) - 16);
    run("poke", 50);

    // Asynchronous reset in the middle of FC.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    held = '0;
    check_outputs("abort", held);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("fresh", 0);

    // Back-to-back runs with two different matrices.
    for (int r = 0; r < MS; r++) for (int k = 0; k < MS; k++) mat[r][k] = DW'($urandom_range(0, 255));
    run("b2b_a", 0);
    for (int r = 0; r < MS; r++) for (int k = 0; k < MS; k++) mat[r][k] = DW'($urandom_range(0, 255));
    for (int c = 0; c < NC; c++) bs[c] = DW'($urandom_range(0, 255));
    run("b2b_b", 0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("b2b_idle_hold", held);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mlp_cls_head.md
Name: mlp_cls_head

Overview:
- Classification head directly downstream of the MLP/residual block in the ECG transformer datapath.
- Consumes the block's 16x16 token-by-feature output matrix and mean-pools each feature column over the tokens.
- Applies a small fully connected layer (features to classes) on a single serial MAC, then selects the winning class by argmax.
- Produces per-class saturated logits and a class index, with a one-cycle done pulse.

Parameters:
- MATRIX_SIZE, 16: tokens (rows) = features (columns); must be a power of two.
- DATA_WIDTH, 8: signed width of matrix, weights, bias and logits.
- NUM_CLASS, 5: number of output classes (ECG beat types).
- FRAC_SHIFT, 4: fixed-point fraction bits of the weights; the MAC result is arithmetic-shifted right by this amount.
- ACC_WIDTH, 24: signed accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins one classification; sampled only in IDLE.
- mat_in  in  DATA_WIDTH x MATRIX_SIZE x MATRIX_SIZE  signed [token][feature] matrix from the MLP stage.
- head_wt  in  DATA_WIDTH x NUM_CLASS*MATRIX_SIZE  signed, flat; weight(c,k) = head_wt[c*MATRIX_SIZE+k].
- head_bs  in  DATA_WIDTH x NUM_CLASS  signed bias, in integer (unshifted) units.
- busy  out  1  high in POOL, FC and DONE.
- done  out  1  one-cycle pulse when results are valid.
- logits  out  DATA_WIDTH x NUM_CLASS  signed saturated logits; held until the next start.
- class_id  out  $clog2(NUM_CLASS)  argmax index; held until the next start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; busy=0, done=0, logits all 0, class_id=0; all counters, accumulators and pooled registers cleared. Asserting rst_n mid-operation aborts immediately, with no partial results retained.
- States: IDLE, POOL, FC, DONE.
- IDLE to POOL on start=1. In any other state, start is ignored (no restart, no queueing).
- On entering POOL, column sums, row counter r, class counter c and feature counter k are cleared. logits and class_id keep their old values until they are overwritten in FC.
- POOL, MATRIX_SIZE cycles: each cycle adds row mat_in[r][*] into MATRIX_SIZE sign-extended column sums (DATA_WIDTH+log2(MATRIX_SIZE) bits), then r++.
  - After the last row: pooled[k] = colsum[k] >>> log2(MATRIX_SIZE), i.e. floor division, which always fits in DATA_WIDTH.
  - Transition to FC.
- FC, NUM_CLASS*MATRIX_SIZE cycles, one MAC per cycle:
  - k=0: acc = (head_bs[c] <<< FRAC_SHIFT) + pooled[0]*wt(c,0).
  - k>0: acc += pooled[k]*wt(c,k).
  - At k=MATRIX_SIZE-1 (same cycle's final MAC included), compute v = final_acc >>> FRAC_SHIFT, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and write logits[c]=v.
  - Argmax in the same cycle: if c==0 or v > best, then best=v and class_id=c. Strict greater-than means ties keep the lower index. The comparison uses the saturated value.
  - Then c++, k=0. After c=NUM_CLASS-1, go to DONE.
- DONE, 1 cycle: done=1 (registered, high for exactly this cycle), then IDLE.
- Latency: with start sampled at edge 0, done is high in the cycle after edge MATRIX_SIZE + NUM_CLASS*MATRIX_SIZE + 1. Defaults give done high during cycle 97. start may re-arm on the cycle after done.
- Input stability: mat_in, head_wt and head_bs must be held stable from start until done; they are not captured.
- Accumulator: 8x8 products, 16 terms and shifted bias need at most 22 bits, so ACC_WIDTH=24 never overflows.

Test Plan:
- Zero matrix, head_bs={3,-1,0,7,2}, any weights: logits={3,-1,0,7,2}, class_id=3, done pulse exactly 1 cycle, 97 cycles after start.
- mat_in all 16, wt(2,*)=1 and all others 0, bias 0: pooled=16, acc=256, logits={0,0,16,0,0}, class_id=2.
- mat_in all 127, wt(0,*)=127, bias 0: raw result 16129 saturates to logits[0]=127, class_id=0. Same with wt(0,*)=-128: logits[0]=-128, and class_id is the first class with logit 0, i.e. 1.
- mat_in row0 all -1, other rows 0, wt(1,*)=16, bias 0: pooled=-1 (floor), logits[1]=-16, logits[0,2..4]=0, class_id=0. Also covers the tie rule.
- Start pulsed again during FC: ignored, result and timing unchanged. rst_n low during FC: busy, done, logits and class_id go to 0 asynchronously. A fresh start then gives a correct result.
- Back-to-back starts with two different matrices: the second result replaces the first, and logits hold their values between runs.
